sdram_rdburst_collector: RTL
============================

Name: sdram_rdburst_collector

Overview:
- Read-side consumer of the SDRAM read-data path, in the AHB clock domain.
- Runs after the mesochronous synchronizer has moved SDRAM read beats across.
- Collects one expected read burst per request, buffers its beats in a small FIFO, tags the final beat, and hands beats to the AHB slave logic over a valid/ready handshake.
- Flags beats that arrive unexpectedly or that cannot be stored.

Parameters:
- DATA_SIZE, 32, width of a read beat in bits.
- FIFO_DEPTH, 4, number of buffered beats; power of 2, at least 2.
- LEN_SIZE, 4, width of burst length field; maximum burst is 2**LEN_SIZE beats.

Ports:
- clk_i  input  1  single block clock.
- rst_i  input  1  synchronous reset, active-high.
- rd_start_i  input  1  a read burst has been issued; load the length.
- rd_len_i  input  LEN_SIZE  beats in the burst minus 1.
- rdvalid_i  input  1  synchronized read beat present this cycle; no backpressure possible.
- rddata_i  input  DATA_SIZE  synchronized read beat.
- rdata_o  output  DATA_SIZE  head-of-FIFO beat.
- rvalid_o  output  1  rdata_o is valid.
- rlast_o  output  1  rdata_o is the last beat of its burst; qualified by rvalid_o.
- rready_i  input  1  consumer accepts the beat.
- busy_o  output  1  a burst is in progress (collecting or draining).
- overflow_o  output  1  sticky: a beat was dropped because the FIFO was full.
- spurious_o  output  1  sticky: a beat arrived while no burst was expected.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - State becomes IDLE.
  - FIFO is emptied; read pointer, write pointer and count are cleared.
  - Beat counter becomes 0.
  - rvalid_o, rlast_o, busy_o, overflow_o and spurious_o become 0; rdata_o is don't-care.
  - Reset in any state aborts the burst and discards buffered beats.
- States:
  - IDLE:
    - rd_start_i=1 loads the beat counter with rd_len_i and moves to COLLECT.
    - rdvalid_i=1 sets spurious_o and the beat is discarded.
  - COLLECT:
    - Each accepted beat (rdvalid_i=1) is pushed with tag last = (counter==0), then the counter decrements.
    - On the beat tagged last, move to DRAIN.
    - rd_start_i is ignored.
  - DRAIN:
    - rdvalid_i=1 sets spurious_o and the beat is discarded.
    - rd_start_i is ignored.
    - Move to IDLE in the cycle the last-tagged beat is popped.
- busy_o = (state != IDLE).
- A beat tagged last is pushed even when the FIFO is full and dropped. The state still advances, so a lost beat never hangs the FSM.
- FIFO:
  - Each entry holds DATA_SIZE+1 bits: data plus last tag.
  - Registered storage with no bypass. A beat pushed at edge n is visible on rdata_o/rvalid_o after edge n, and can be popped at edge n+1 at the earliest.
  - rvalid_o = (count != 0); rlast_o = tag of the head entry.
  - Pop happens when rvalid_o && rready_i.
  - Push is permitted when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the beat is dropped and overflow_o is set.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- rdata_o stays stable while rvalid_o=1 and rready_i=0.
- overflow_o and spurious_o clear only on reset.
- rd_start_i and rdvalid_i in the same cycle while in IDLE: the counter loads and the state goes to COLLECT, but that beat counts as spurious and is not stored.

Test Plan:
- Single burst: reset, then rd_start_i with rd_len_i=3, then 4 consecutive rdvalid_i beats 0xA0..0xA3 with rready_i=1.
  - Required: rvalid_o one cycle after each beat, data 0xA0..0xA3 in order.
  - Required: rlast_o only with 0xA3; busy_o falls in the cycle after 0xA3 is popped; no flags set.
- Backpressure: rd_len_i=3, rready_i=0 while 4 beats arrive.
  - Required: count reaches 4, rdata_o holds 0xA0.
  - Then rready_i=1: 4 pops in 4 cycles, then IDLE.
- Overflow: FIFO_DEPTH=4, rd_len_i=5, rready_i=0, 6 beats 0x10..0x15.
  - Required: overflow_o=1 from the 5th beat.
  - Required: FIFO holds 0x10..0x13 with no last tag; state goes to DRAIN on the 6th beat.
- Full with simultaneous pop: FIFO full, rready_i=1 in the same cycle as a new beat.
  - Required: beat stored, count stays 4, overflow_o=0.
- Spurious and ignored start:
  - rdvalid_i in IDLE sets spurious_o=1.
  - rd_start_i during COLLECT with rd_len_i=0 does not alter the remaining count of the original rd_len_i=2 burst; 3 beats are still expected.
- Reset mid-burst: rst_i=1 after 2 of 4 beats.
  - Required: next cycle rvalid_o=0, busy_o=0, flags 0.
  - Required: a fresh rd_len_i=0 burst delivers its single beat with rlast_o=1.

Source files
------------

// File: rtl/sdram_rdburst_collector_if.sv
// Bundles the burst-request, synchronized read-beat and consumer-handshake signals of the read collector.
// The slave side is the collector; the master side is whoever drives requests, beats and rready.
interface sdram_rdburst_collector_if #(
    parameter int DATA_SIZE = 32,
    parameter int LEN_SIZE  = 4
);
    logic                 rd_start_i;
    logic [LEN_SIZE-1:0]  rd_len_i;
    logic                 rdvalid_i;
    logic [DATA_SIZE-1:0] rddata_i;
    logic [DATA_SIZE-1:0] rdata_o;
    logic                 rvalid_o;
    logic                 rlast_o;
    logic                 rready_i;
    logic                 busy_o;
    logic                 overflow_o;
    logic                 spurious_o;

    modport slave (
        input  rd_start_i, rd_len_i, rdvalid_i, rddata_i, rready_i,
        output rdata_o, rvalid_o, rlast_o, busy_o, overflow_o, spurious_o
    );

    modport master (
        output rd_start_i, rd_len_i, rdvalid_i, rddata_i, rready_i,
        input  rdata_o, rvalid_o, rlast_o, busy_o, overflow_o, spurious_o
    );
endinterface

// File: rtl/sdram_rdburst_collector.sv
// Collects one SDRAM read burst per request into a small FIFO, tags the final beat, flags stray/dropped beats.
// One-cycle push-to-rvalid latency; read beats cannot be stalled, so a full FIFO drops the beat and sets overflow.
module sdram_rdburst_collector #(
    parameter int DATA_SIZE  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_SIZE   = 4
) (
    input logic                     clk_i,
    input logic                     rst_i,
    sdram_rdburst_collector_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_overflow;
    logic                 r_spurious;
    logic [LEN_SIZE-1:0]  r_beat_cnt;

    logic [DATA_SIZE:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_valid;
    logic [DATA_SIZE:0]   w_head;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_collect_beat;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_tag_last;
    logic                 w_stray;
    logic                 w_drain_done;

    assign w_valid        = (r_count != '0);
    assign w_head         = r_mem[r_rd_ptr];
    assign w_pop          = w_valid && bus.rready_i;
    assign w_full         = (r_count == CW'(FIFO_DEPTH));
    assign w_collect_beat = (r_state == S_COLLECT) && bus.rdvalid_i;
    assign w_push         = w_collect_beat && (!w_full || w_pop);
    assign w_drop         = w_collect_beat && !w_push;
    assign w_tag_last     = (r_beat_cnt == '0);
    assign w_stray        = bus.rdvalid_i && (r_state != S_COLLECT);
    // Popping the sole remaining entry also ends DRAIN, covering a burst whose last beat was dropped.
    assign w_drain_done   = w_pop && (w_head[DATA_SIZE] || (r_count == CW'(1)));

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_tag_last, bus.rddata_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_beat_cnt <= '0;
            r_overflow <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            if (w_stray) r_spurious <= 1'b1;
            if (w_drop)  r_overflow <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (bus.rd_start_i) begin
                        r_beat_cnt <= bus.rd_len_i;
                        r_state    <= S_COLLECT;
                        r_busy     <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (bus.rdvalid_i) begin
                        r_beat_cnt <= r_beat_cnt - LEN_SIZE'(1);
                        if (w_tag_last) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata_o    = w_head[DATA_SIZE-1:0];
    assign bus.rvalid_o   = w_valid;
    assign bus.rlast_o    = w_valid && w_head[DATA_SIZE];
    assign bus.busy_o     = r_busy;
    assign bus.overflow_o = r_overflow;
    assign bus.spurious_o = r_spurious;
endmodule
